// File: rtl/decoder_scan_n_if.sv
// Bus bundle for decoder_scan_n: control strobes in, registered select outputs back.
// Handshake: load is a one-cycle strobe with no ready; the block accepts it on every enabled edge. valid marks a y with exactly one active line.
interface decoder_scan_n_if #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8
);
  logic               en;
  logic               mode;
  logic               load;
  logic [SEL_W-1:0]   sel_in;
  logic [NUM_OUT-1:0] y;
  logic [SEL_W-1:0]   idx;
  logic               valid;
  logic               step;
  logic               range_err;

  modport master (
    output en, mode, load, sel_in,
    input  y, idx, valid, step, range_err
  );

  modport slave (
    input  en, mode, load, sel_in,
    output y, idx, valid, step, range_err
  );
endinterface

// File: rtl/decoder_scan_n.sv
// Registered one-hot decoder with selectable polarity; direct mode decodes a loaded index,
// scan mode advances the index every PRESCALE enabled cycles for display/keypad multiplexing.
module decoder_scan_n #(
  parameter int SEL_W      = 3,
  parameter int NUM_OUT    = 8,
  parameter int ACTIVE_LOW = 0,
  parameter int PRESCALE   = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  decoder_scan_n_if.slave bus
);

  localparam int                 CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [SEL_W-1:0]   IDX_LAST = SEL_W'(NUM_OUT - 1);
  localparam logic [NUM_OUT-1:0] INACTIVE = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic [NUM_OUT-1:0] y_q, y_d;
  logic               valid_q, valid_d;
  logic               step_q, step_d;
  logic               err_q, err_d;
  logic [NUM_OUT-1:0] onehot;
  logic               sel_ok;
  logic               mode_change;

  assign sel_ok      = (32'(bus.sel_in) < NUM_OUT);
  assign mode_change = (bus.mode != mode_q);

  always_comb begin
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    step_d  = 1'b0;
    err_d   = 1'b0;
    valid_d = 1'b0;
    onehot  = '0;
    y_d     = INACTIVE;
    if (bus.en) begin
      mode_d  = bus.mode;
      valid_d = 1'b1;
      if (bus.load && sel_ok) begin
        idx_d = bus.sel_in;
        cnt_d = '0;
      end else if (bus.load) begin
        // Rejected load keeps index and phase; only a mode change may still clear the phase.
        err_d   = 1'b1;
        valid_d = 1'b0;
        if (mode_change) cnt_d = '0;
      end else if (mode_change || !bus.mode) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        step_d = 1'b1;
        idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      // Decode the next index so y and idx land on the same edge.
      for (int i = 0; i < NUM_OUT; i++) begin
        onehot[i] = (idx_d == SEL_W'(i));
      end
      if (valid_d) y_d = onehot ^ INACTIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      y_q     <= INACTIVE;
      valid_q <= 1'b0;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      step_q  <= step_d;
      err_q   <= err_d;
    end
  end

  assign bus.y         = y_q;
  assign bus.idx       = idx_q;
  assign bus.valid     = valid_q;
  assign bus.step      = step_q;
  assign bus.range_err = err_q;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Drives four differently parameterised decoders from one stimulus stream and checks each
// against a cycle-level behavioural model of index, scan phase and output polarity.
module tb_decoder_scan_n;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic       load;
  logic [7:0] sel;

  int n_checks;
  int n_fails;

  // Per-instance parameters: A (8 out, P=4), B (active-low, P=2), C (6 out, P=3), D (3 out, P=1)
  int p_sw [4] = '{3, 3, 3, 2};
  int p_n  [4] = '{8, 8, 6, 3};
  int p_al [4] = '{0, 1, 0, 0};
  int p_p  [4] = '{4, 2, 3, 1};

  int m_idx  [4];
  int m_cnt  [4];
  int m_prev [4];

  logic [7:0] e_y   [4];
  logic [7:0] e_idx [4];
  logic       e_v   [4];
  logic       e_s   [4];
  logic       e_e   [4];

  logic [7:0] o_y   [4];
  logic [7:0] o_idx [4];
  logic [3:0] o_v, o_s, o_e;

  decoder_scan_n_if #(.SEL_W(3), .NUM_OUT(8)) if_a ();
  decoder_scan_n_if #(.SEL_W(3), .NUM_OUT(8)) if_b ();
  decoder_scan_n_if #(.SEL_W(3), .NUM_OUT(6)) if_c ();
  decoder_scan_n_if #(.SEL_W(2), .NUM_OUT(3)) if_d ();

  assign if_a.en = en;  assign if_a.mode = mode;  assign if_a.load = load;  assign if_a.sel_in = sel[2:0];
  assign if_b.en = en;  assign if_b.mode = mode;  assign if_b.load = load;  assign if_b.sel_in = sel[2:0];
  assign if_c.en = en;  assign if_c.mode = mode;  assign if_c.load = load;  assign if_c.sel_in = sel[2:0];
  assign if_d.en = en;  assign if_d.mode = mode;  assign if_d.load = load;  assign if_d.sel_in = sel[1:0];

  decoder_scan_n #(.SEL_W(3), .NUM_OUT(8), .ACTIVE_LOW(0), .PRESCALE(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  decoder_scan_n #(.SEL_W(3), .NUM_OUT(8), .ACTIVE_LOW(1), .PRESCALE(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  decoder_scan_n #(.SEL_W(3), .NUM_OUT(6), .ACTIVE_LOW(0), .PRESCALE(3)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
  decoder_scan_n #(.SEL_W(2), .NUM_OUT(3), .ACTIVE_LOW(0), .PRESCALE(1)) u_d (.clk(clk), .rst_n(rst_n), .bus(if_d));

  assign o_y[0]   = if_a.y;
  assign o_y[1]   = if_b.y;
  assign o_y[2]   = {2'b00, if_c.y};
  assign o_y[3]   = {5'b00000, if_d.y};
  assign o_idx[0] = {5'b00000, if_a.idx};
  assign o_idx[1] = {5'b00000, if_b.idx};
  assign o_idx[2] = {5'b00000, if_c.idx};
  assign o_idx[3] = {6'b000000, if_d.idx};
  assign o_v = {if_d.valid, if_c.valid, if_b.valid, if_a.valid};
  assign o_s = {if_d.step, if_c.step, if_b.step, if_a.step};
  assign o_e = {if_d.range_err, if_c.range_err, if_b.range_err, if_a.range_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // Reference: what one rising edge does to instance k, given the inputs now applied.
  task automatic model_edge(input int k);
    int  s;
    int  mask;
    int  inact;
    bit  err;
    bit  stp;
    mask  = (1 << p_n[k]) - 1;
    inact = (p_al[k] != 0) ? mask : 0;
    s     = int'(sel) % (1 << p_sw[k]);
    err   = 1'b0;
    stp   = 1'b0;
    if (!rst_n) begin
      m_idx[k] = 0; m_cnt[k] = 0; m_prev[k] = 0;
      e_y[k] = 8'(inact); e_v[k] = 1'b0; e_s[k] = 1'b0; e_e[k] = 1'b0;
    end else if (!en) begin
      e_y[k] = 8'(inact); e_v[k] = 1'b0; e_s[k] = 1'b0; e_e[k] = 1'b0;
    end else begin
      if (load) begin
        if (s < p_n[k]) begin
          m_idx[k] = s;
          m_cnt[k] = 0;
        end else begin
          err = 1'b1;
          if (int'(mode) != m_prev[k]) m_cnt[k] = 0;
        end
      end else if (int'(mode) != m_prev[k] || !mode) begin
        m_cnt[k] = 0;
      end else if (m_cnt[k] == p_p[k] - 1) begin
        m_cnt[k] = 0;
        m_idx[k] = (m_idx[k] + 1) % p_n[k];
        stp = 1'b1;
      end else begin
        m_cnt[k] = m_cnt[k] + 1;
      end
      m_prev[k] = int'(mode);
      e_y[k] = err ? 8'(inact) : 8'((1 << m_idx[k]) ^ inact);
      e_v[k] = !err;
      e_s[k] = stp;
      e_e[k] = err;
    end
    e_idx[k] = 8'(m_idx[k]);
  endtask

  task automatic cycle(input logic r, input logic e, input logic m, input logic l, input logic [7:0] s);
    rst_n = r; en = e; mode = m; load = l; sel = s;
    for (int k = 0; k < 4; k++) model_edge(k);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      check("y",         k, o_y[k],          e_y[k]);
      check("idx",       k, o_idx[k],        e_idx[k]);
      check("valid",     k, 8'(o_v[k]),      8'(e_v[k]));
      check("step",      k, 8'(o_s[k]),      8'(e_s[k]));
      check("range_err", k, 8'(o_e[k]),      8'(e_e[k]));
    end
  endtask

  initial begin
    int held;
    logic rm;
    n_checks = 0;
    n_fails  = 0;
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; sel = 8'd0;

    // Reset: all outputs inactive.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    check("rst_y_a",  0, o_y[0], 8'h00);
    check("rst_y_b",  1, o_y[1], 8'hFF);
    check("rst_v_a",  0, 8'(o_v[0]), 8'd0);

    // Direct load of 5.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'd5);
    check("ld5_y",   0, o_y[0], 8'h20);
    check("ld5_idx", 0, o_idx[0], 8'd5);

    // Active-low load of 2, then disable.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'd2);
    check("al_y", 1, o_y[1], 8'hFB);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    check("al_off_y",   1, o_y[1], 8'hFF);
    check("al_off_v",   1, 8'(o_v[1]), 8'd0);
    check("al_off_idx", 1, o_idx[1], 8'd2);

    // Scan wrap on the 6-output, P=3 instance starting from idx 4.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'd4);
    check("c_ld4", 2, o_idx[2], 8'd4);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
      check("c_step", 2, 8'(o_s[2]), (i > 0 && i % 3 == 0) ? 8'd1 : 8'd0);
      if (i == 3) check("c_idx5", 2, o_idx[2], 8'd5);
      if (i == 6) check("c_wrap_y", 2, o_y[2], 8'h01);
    end
    check("c_idx1", 2, o_idx[2], 8'd1);

    // Out-of-range load on the 6-output instance.
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'd7);
    check("c_err",     2, 8'(o_e[2]), 8'd1);
    check("c_err_y",   2, o_y[2], 8'h00);
    check("c_err_idx", 2, o_idx[2], 8'd1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    check("c_err_pulse", 2, 8'(o_e[2]), 8'd0);

    // Load colliding with terminal count on instance A.
    for (int i = 0; i < 8; i++) begin
      if (m_cnt[0] == 3) break;
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    end
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'd3);
    check("col_idx",  0, o_idx[0], 8'd3);
    check("col_step", 0, 8'(o_s[0]), 8'd0);
    for (int j = 1; j <= 4; j++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
      check("col_next_step", 0, 8'(o_s[0]), (j == 4) ? 8'd1 : 8'd0);
    end
    check("col_next_idx", 0, o_idx[0], 8'd4);

    // Reset mid-scan, then first enabled cycle decodes index 0.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    check("mid_rst_idx", 0, o_idx[0], 8'd0);
    check("mid_rst_y",   0, o_y[0], 8'h00);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    check("post_rst_y", 0, o_y[0], 8'h01);
    check("post_rst_v", 0, 8'(o_v[0]), 8'd1);

    // Mode toggle 1->0->1 keeps idx and restarts the full interval.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    held = m_idx[0];
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    check("tog_idx", 0, o_idx[0], 8'(held));
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    check("tog_re_idx", 0, o_idx[0], 8'(held));
    for (int j = 1; j <= 4; j++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
      check("tog_step", 0, 8'(o_s[0]), (j == 4) ? 8'd1 : 8'd0);
    end

    // PRESCALE=1 instance steps on every enabled scan cycle.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
      check("p1_step", 3, 8'(o_s[3]), 8'd1);
    end

    // Randomised traffic.
    rm = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) rm = ~rm;
      cycle(($urandom_range(0, 39) != 0), ($urandom_range(0, 7) != 0), rm,
            ($urandom_range(0, 5) == 0), 8'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/decoder_scan_n.md
Name: decoder_scan_n

Overview:
Parametrised registered one-hot decoder with selectable output polarity and two operating modes. In direct mode it decodes a loaded index. In scan mode it auto-advances the index at a prescaled rate, which suits digit/row select for multiplexed displays and keypads. It replaces the fixed 2-to-4 and 3-to-8 combinational decoders wherever a registered or scanning select is needed.

Parameters:
SEL_W, 3, index width in bits; legal range 1..8.
NUM_OUT, 8, number of decoded outputs; legal range 2..2**SEL_W; indices NUM_OUT..2**SEL_W-1 are out of range.
ACTIVE_LOW, 0, output polarity: 0 = selected line 1, others 0; 1 = selected line 0, others 1.
PRESCALE, 4, clock cycles per scan step; must be >= 1.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous reset, active-low
en  input  1  global enable; 0 forces outputs inactive and freezes state
mode  input  1  0 = direct, 1 = scan
load  input  1  single-cycle strobe: capture sel_in as new index
sel_in  input  SEL_W  index to load
y  output  NUM_OUT  registered decoded outputs, polarity per ACTIVE_LOW
idx  output  SEL_W  current registered index
valid  output  1  1 when y has exactly one active line
step  output  1  one-cycle pulse on the edge where scan advances idx
range_err  output  1  one-cycle pulse when a load carries sel_in >= NUM_OUT

Behaviour:
- Inactive level: "inactive" = 0 when ACTIVE_LOW=0, 1 when ACTIVE_LOW=1. An all-inactive y is all 0s or all 1s accordingly.
- Reset (rst_n=0 at a clk edge): idx=0, prescale counter=0, y=all inactive, valid=0, step=0, range_err=0. Reset overrides every other input, including mid-scan.
- Same-edge update: y, idx and valid always update on the same edge. y is the decode of the new idx, never a cycle behind.
- en=0: on the next edge y=all inactive, valid=0, step=0, range_err=0. idx and the prescale counter hold their values.
- en returning to 1: the next edge drives y=decode(idx), valid=1. The prescale counter resumes from its held value.
- Load, either mode (en=1, load=1):
  - sel_in < NUM_OUT: next edge gives idx=sel_in, y=decode(sel_in), valid=1. Prescale counter clears to 0. Latency is 1 cycle.
  - sel_in >= NUM_OUT: next edge gives range_err=1 for one cycle, y=all inactive, valid=0. idx and the prescale counter are unchanged.
- Direct mode (mode=0, en=1, no load): idx and y hold. The prescale counter stays at 0. step is never asserted.
- Scan mode (mode=1, en=1, no load):
  - The prescale counter counts 0..PRESCALE-1.
  - On the edge where the counter equals PRESCALE-1: counter goes to 0, idx advances (NUM_OUT-1 wraps to 0), y updates, step=1 for that one cycle, valid=1.
  - PRESCALE=1 advances idx every enabled cycle, with step held high.
  - Scan period is PRESCALE*NUM_OUT cycles.
- Load and terminal count in the same cycle: load wins. idx=sel_in, counter clears to 0, step=0.
- Mode change: on any edge where mode differs from its registered previous value, the prescale counter clears to 0 and idx is retained. Scan therefore resumes from the current idx with a full PRESCALE interval before the first step.
- First cycle after reset with en=1 and no load: y=decode(0), valid=1.
- valid=1 if and only if exactly one line of y is active.

Test Plan:
- Reset/direct, SEL_W=3, NUM_OUT=8, ACTIVE_LOW=0: hold rst_n=0 -> y=8'h00, valid=0. Release, en=1, load sel_in=5 -> next cycle y=8'h20, idx=5, valid=1.
- Active-low, ACTIVE_LOW=1: load sel_in=2 -> y=8'hFB. Drop en -> next cycle y=8'hFF, valid=0, idx still 2.
- Scan wrap, NUM_OUT=6, PRESCALE=3, mode=1 from idx=4:
  - step pulses every 3rd cycle; idx sequence 5,0,1.
  - y goes 6'b100000 -> 6'b000001 at the wrap.
- Range error, NUM_OUT=6: load sel_in=7 -> range_err high for 1 cycle, y=0, valid=0, idx unchanged.
- Collision, PRESCALE=4 scanning: assert load sel_in=3 on the cycle the counter=3 -> idx=3, step=0. Next step arrives exactly 4 cycles later with idx=4.
- Mid-operation events:
  - Reset asserted mid-scan at idx=4 -> next edge idx=0, y=inactive.
  - Toggle mode 1->0->1 -> idx retained; first step comes PRESCALE cycles after re-entry.
  - PRESCALE=1 -> step stays high and idx increments every cycle.
